// File: rtl/boot_pkg.sv
// Shared boot-path definitions: loader FSM state encoding and stream framing constants.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_LEN_HI  = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_DATA_HI = 3'd4,
        ST_WRITE   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } loader_state_t;

    localparam int BYTES_PER_WORD = 2;
    localparam int LEN_BYTES      = 2;

    // States in which the loader is waiting for a start pulse.
    function automatic logic is_parked(input loader_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/bram_word_loader_if.sv
// Byte-stream input, BRAM port-A output and boot-controller status of the word loader.
interface bram_word_loader_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              wea;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_written;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, addra, dina, wea, busy, done, err, words_written
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, addra, dina, wea, busy, done, err, words_written
    );
endinterface

// File: rtl/bram_word_loader.sv
// Boot loader: parses a little-endian word count and word stream from a byte source
// and writes the words to consecutive BRAM addresses starting at BASE_ADDR.
module bram_word_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    bram_word_loader_if.slave bus
);

    localparam int unsigned       MAX_WORDS = (32'd1 << ADDR_W) - 32'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WORD_ONE  = (ADDR_W + 1)'(1);

    loader_state_t     r_state;
    loader_state_t     w_state_nxt;

    logic [15:0]       r_count;
    logic [ADDR_W-1:0] r_addra;
    logic [DATA_W-1:0] r_dina;
    logic              r_wea;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_words;

    logic              w_rx_ready;
    logic              w_accept;
    logic              w_last_word;
    logic [15:0]       w_len;

    assign w_accept    = bus.rx_valid && w_rx_ready;
    assign w_len       = {bus.rx_data, r_count[7:0]};
    assign w_last_word = (32'(r_words) + 32'd1) == 32'(r_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rx_ready  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.start) w_state_nxt = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                w_rx_ready = 1'b1;
                if (w_accept) w_state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                w_rx_ready = 1'b1;
                if (w_accept) begin
                    if (w_len == 16'd0)
                        w_state_nxt = ST_DONE;
                    else if (32'(w_len) > MAX_WORDS)
                        w_state_nxt = ST_ERR;
                    else
                        w_state_nxt = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                w_rx_ready = 1'b1;
                if (w_accept) w_state_nxt = ST_DATA_HI;
            end
            ST_DATA_HI: begin
                w_rx_ready = 1'b1;
                if (w_accept) w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                w_state_nxt = w_last_word ? ST_DONE : ST_DATA_LO;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The BRAM samples addra/dina during the single WRITE cycle, so both only move afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_addra <= ADDR_BASE;
            r_dina  <= '0;
            r_wea   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_words <= '0;
        end else begin
            r_wea <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (bus.start) begin
                        r_count <= '0;
                        r_addra <= ADDR_BASE;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_words <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) r_count[7:0] <= bus.rx_data;
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_count[15:8] <= bus.rx_data;
                        r_done        <= (w_state_nxt == ST_DONE);
                        r_err         <= (w_state_nxt == ST_ERR);
                    end
                end
                ST_DATA_LO: begin
                    if (w_accept) r_dina[7:0] <= bus.rx_data;
                end
                ST_DATA_HI: begin
                    if (w_accept) begin
                        r_dina[DATA_W-1:8] <= bus.rx_data;
                        r_wea              <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_addra <= r_addra + ADDR_ONE;
                    r_words <= r_words + WORD_ONE;
                    r_done  <= (w_state_nxt == ST_DONE);
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready      = w_rx_ready;
    assign bus.addra         = r_addra;
    assign bus.dina          = r_dina;
    assign bus.wea           = r_wea;
    assign bus.busy          = !is_parked(r_state);
    assign bus.done          = r_done;
    assign bus.err           = r_err;
    assign bus.words_written = r_words;

endmodule

// File: tb/tb_bram_word_loader.sv
// Directed and randomized bench for bram_word_loader against a stream-level reference model.
module tb_bram_word_loader;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;

    bram_word_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bram_word_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [26:0] wr_q[$];
    logic [26:0] exp_q[$];
    logic        e_done;
    logic        e_err;
    int          e_words;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Observed BRAM port-A writes; rx_ready must be low whenever wea is high.
    always @(negedge clk) begin
        if (bus.wea === 1'b1) begin
            wr_q.push_back({bus.addra, bus.dina});
            chk("rdy_during_wea", 32'(bus.rx_ready), 32'd0);
        end
    end

    task automatic model(input bq_t b);
        int cnt;
        cnt = int'(b[0]) + 256 * int'(b[1]);
        exp_q.delete();
        e_done  = 1'b0;
        e_err   = 1'b0;
        e_words = 0;
        if (cnt == 0) begin
            e_done = 1'b1;
        end else if (cnt > DEPTH) begin
            e_err = 1'b1;
        end else begin
            for (int i = 0; i < cnt; i++)
                exp_q.push_back({11'(i), b[3 + 2*i], b[2 + 2*i]});
            e_done  = 1'b1;
            e_words = cnt;
        end
    endtask

    function automatic bq_t mk_load(input int cnt, input int nwords);
        bq_t q;
        q.push_back(8'(cnt));
        q.push_back(8'(cnt >> 8));
        for (int i = 0; i < 2 * nwords; i++)
            q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        int n;
        n = 0;
        bus.rx_data  = v;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            chk("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
            return;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_load(input string tag, input bq_t b, input int gap_max, input int poke);
        int n;
        int bad;
        model(b);
        wr_q.delete();
        pulse_start();
        chk({tag, "_clr_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_clr_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_clr_words"}, 32'(bus.words_written), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        for (int k = 0; k < b.size(); k++) begin
            if (k == poke) begin
                bus.rx_valid = 1'b0;
                pulse_start();
                chk({tag, "_poke_busy"}, 32'(bus.busy), 32'd1);
            end
            send_byte(b[k]);
            if (gap_max > 0) begin
                bus.rx_valid = 1'b0;
                n = $urandom_range(0, gap_max);
                repeat (n) begin @(posedge clk); #1; end
            end
        end
        bus.rx_valid = 1'b0;
        if (e_words == 0) begin
            chk({tag, "_done_now"}, 32'(bus.done), 32'(e_done));
            chk({tag, "_err_now"}, 32'(bus.err), 32'(e_err));
        end else if (gap_max == 0) begin
            chk({tag, "_last_wea"}, 32'(bus.wea), 32'd1);
            chk({tag, "_last_rdy"}, 32'(bus.rx_ready), 32'd0);
            chk({tag, "_last_notdone"}, 32'(bus.done), 32'd0);
            @(posedge clk); #1;
            chk({tag, "_done_next"}, 32'(bus.done), 32'd1);
        end
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk({tag, "_done"}, 32'(bus.done), 32'(e_done));
        chk({tag, "_err"}, 32'(bus.err), 32'(e_err));
        chk({tag, "_words"}, 32'(bus.words_written), 32'(e_words));
        chk({tag, "_rdy_off"}, 32'(bus.rx_ready), 32'd0);
        chk({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            if (wr_q[i] !== exp_q[i]) bad++;
        chk({tag, "_wr_bad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t b;
        bus.start    = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(bus.rx_ready), 32'd0);
        chk("rst_addra", 32'(bus.addra), 32'd0);
        chk("rst_dina", 32'(bus.dina), 32'd0);
        chk("rst_wea", 32'(bus.wea), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_words", 32'(bus.words_written), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Three-word ungapped load with literal expectations
        b = '{8'h03, 8'h00, 8'hAA, 8'h11, 8'hBB, 8'h22, 8'hCC, 8'h33};
        run_load("three", b, 0, -1);
        chk("three_w0", 32'(wr_q[0]), {5'd0, 11'd0, 16'h11AA});
        chk("three_w1", 32'(wr_q[1]), {5'd0, 11'd1, 16'h22BB});
        chk("three_w2", 32'(wr_q[2]), {5'd0, 11'd2, 16'h33CC});

        // Zero-length load
        b = '{8'h00, 8'h00};
        run_load("zero", b, 0, -1);

        // Count 2049 exceeds depth
        b = '{8'h01, 8'h08};
        run_load("over", b, 0, -1);
        bus.rx_data  = 8'h55;
        bus.rx_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("over_rdy_hold", 32'(bus.rx_ready), 32'd0);
        chk("over_nowr", 32'(wr_q.size()), 32'd0);
        bus.rx_valid = 1'b0;

        // Count 0xFFFF also rejected
        b = '{8'hFF, 8'hFF};
        run_load("ffff", b, 0, -1);

        // Two words with one-cycle gaps between bytes
        b = mk_load(2, 2);
        run_load("gap2", b, 1, -1);

        // Randomized short loads with random gaps
        for (int t = 0; t < 6; t++) begin
            int c;
            c = $urandom_range(1, 12);
            b = mk_load(c, c);
            run_load($sformatf("rnd%0d", t), b, 2, -1);
        end

        // Reset in the middle of word 2 of a 4-word load
        wr_q.delete();
        pulse_start();
        b = mk_load(4, 4);
        for (int k = 0; k < 5; k++) send_byte(b[k]);
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_wea", 32'(bus.wea), 32'd0);
        chk("mrst_addra", 32'(bus.addra), 32'd0);
        chk("mrst_rdy", 32'(bus.rx_ready), 32'd0);
        chk("mrst_dina", 32'(bus.dina), 32'd0);
        chk("mrst_words", 32'(bus.words_written), 32'd0);
        chk("mrst_nwr", 32'(wr_q.size()), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        b = mk_load(4, 4);
        run_load("after_rst", b, 0, -1);

        // Reload after done with a start pulse while busy
        b = '{8'h01, 8'h00, 8'hEF, 8'hBE};
        run_load("beef", b, 0, 2);
        chk("beef_w0", 32'(wr_q[0]), {5'd0, 11'd0, 16'hBEEF});

        // Full-depth load: last write lands at the top address
        b = mk_load(DEPTH, DEPTH);
        run_load("full", b, 0, -1);
        chk("full_last_addr", 32'(wr_q[DEPTH-1][26:16]), 32'(DEPTH - 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
